// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared types and constants for the vending dispense controller
package vm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_VEND   = 2'b01,
        ST_REFUND = 2'b10,
        ST_ERROR  = 2'b11
    } vm_status_e;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_5    = 2'b01,
        COIN_10   = 2'b10,
        COIN_25   = 2'b11
    } vm_coin_e;

    localparam logic [15:0] VAL_5  = 16'd5;
    localparam logic [15:0] VAL_10 = 16'd10;
    localparam logic [15:0] VAL_25 = 16'd25;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOTOR,
        S_CHANGE,
        S_GAP,
        S_DONE,
        S_FAULT
    } vm_state_e;

    // Slot number 1..6 to motor drive bit; anything else drives nothing
    function automatic logic [5:0] slot_onehot(input logic [2:0] slot);
        logic [5:0] oh;
        oh = 6'b000000;
        case (slot)
            3'd1:    oh = 6'b000001;
            3'd2:    oh = 6'b000010;
            3'd3:    oh = 6'b000100;
            3'd4:    oh = 6'b001000;
            3'd5:    oh = 6'b010000;
            3'd6:    oh = 6'b100000;
            default: oh = 6'b000000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/vm_dispense_ctrl_if.sv
// rtl/vm_dispense_ctrl_if.sv - vending-FSM side bundle; vend_cnt present only with VM_DISPENSE_STATS_EN
interface vm_dispense_ctrl_if;
    logic [2:0]  product;
    logic [1:0]  status;
    logic [15:0] balance;
    logic        slot_sense;
    logic [5:0]  motor;
    logic [1:0]  coin_out;
    logic        coin_stb;
    logic        busy;
    logic        done;
    logic        fault;
`ifdef VM_DISPENSE_STATS_EN
    logic [7:0]  vend_cnt;
`endif

    modport master (
        output product, status, balance, slot_sense,
        input  motor, coin_out, coin_stb, busy, done, fault
`ifdef VM_DISPENSE_STATS_EN
        , input vend_cnt
`endif
    );

    modport slave (
        input  product, status, balance, slot_sense,
        output motor, coin_out, coin_stb, busy, done, fault
`ifdef VM_DISPENSE_STATS_EN
        , output vend_cnt
`endif
    );
endinterface

// File: rtl/vm_change_calc.sv
// rtl/vm_change_calc.sv - greedy coin selection and next remaining balance
module vm_change_calc
    import vm_pkg::*;
(
    input  logic [15:0] remaining,
    output vm_coin_e    coin,
    output logic        valid,
    output logic [15:0] next_remaining
);

    // Largest coin that fits; subtraction only happens when it cannot underflow
    always_comb begin
        coin           = COIN_NONE;
        valid          = 1'b0;
        next_remaining = remaining;
        if (remaining >= VAL_25) begin
            coin           = COIN_25;
            valid          = 1'b1;
            next_remaining = remaining - VAL_25;
        end else if (remaining >= VAL_10) begin
            coin           = COIN_10;
            valid          = 1'b1;
            next_remaining = remaining - VAL_10;
        end else if (remaining >= VAL_5) begin
            coin           = COIN_5;
            valid          = 1'b1;
            next_remaining = remaining - VAL_5;
        end
    end

endmodule

// File: rtl/vm_dispense_ctrl.sv
// rtl/vm_dispense_ctrl.sv - dispense controller: slot motor, change payout; VM_DISPENSE_STATS_EN adds vend_cnt
module vm_dispense_ctrl
    import vm_pkg::*;
#(
    parameter int MOTOR_TIMEOUT = 16,
    parameter int COIN_GAP      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 soft_rst,
    vm_dispense_ctrl_if.slave    bus
);

    localparam int TW = $clog2(MOTOR_TIMEOUT + 1);
    localparam int GW = $clog2(COIN_GAP + 1);

    vm_state_e   state_q, state_d;
    logic [1:0]  status_q, status_d;
    logic [2:0]  prod_q, prod_d;
    logic [15:0] remaining_q, remaining_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [5:0]  motor_q, motor_d;
    logic [1:0]  coin_out_q, coin_out_d;
    logic        coin_stb_q, coin_stb_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        busy_q, busy_d;
    logic        req;

    vm_coin_e    calc_coin;
    logic        calc_valid;
    logic [15:0] calc_next;

    vm_change_calc u_calc (
        .remaining      (remaining_q),
        .coin           (calc_coin),
        .valid          (calc_valid),
        .next_remaining (calc_next)
    );

    // Only a fresh 00 -> non-zero status transition seen while idle starts a transaction
    assign req = (state_q == S_IDLE) && (status_q == ST_IDLE) && (bus.status != ST_IDLE);

    // Next state and next registered outputs; soft_rst overrides everything last
    always_comb begin
        state_d     = state_q;
        prod_d      = prod_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        coin_out_d  = coin_out_q;
        coin_stb_d  = 1'b0;
        fault_d     = fault_q;
        status_d    = bus.status;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    prod_d      = bus.product;
                    remaining_d = bus.balance;
                    timer_d     = '0;
                    if (bus.status == ST_REFUND) begin
                        state_d = S_CHANGE;
                    end else if (bus.status == ST_VEND && bus.product >= 3'd1 && bus.product <= 3'd6) begin
                        state_d = S_MOTOR;
                    end else begin
                        // Bad slot or upstream error: nothing is paid out
                        state_d     = S_FAULT;
                        fault_d     = 1'b1;
                        remaining_d = '0;
                    end
                end
            end
            S_MOTOR: begin
                if (bus.slot_sense) begin
                    state_d = S_CHANGE;
                end else if (timer_q == TW'(MOTOR_TIMEOUT - 1)) begin
                    // Jam: stop the motor and refund the whole latched balance
                    state_d = S_CHANGE;
                    fault_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CHANGE: begin
                if (calc_valid) begin
                    coin_stb_d  = 1'b1;
                    coin_out_d  = calc_coin;
                    remaining_d = calc_next;
                    gap_d       = '0;
                    state_d     = (COIN_GAP > 1) ? S_GAP : S_CHANGE;
                end else begin
                    // Sub-5c residue cannot be paid and is dropped
                    remaining_d = '0;
                    state_d     = S_DONE;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(COIN_GAP - 2)) begin
                    state_d = S_CHANGE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (soft_rst) begin
            state_d     = S_IDLE;
            status_d    = 2'b00;
            prod_d      = '0;
            remaining_d = '0;
            timer_d     = '0;
            gap_d       = '0;
            coin_out_d  = 2'b00;
            coin_stb_d  = 1'b0;
            fault_d     = 1'b0;
        end

        motor_d = (state_d == S_MOTOR) ? slot_onehot(prod_d) : 6'b000000;
        done_d  = (state_d == S_DONE) || (state_d == S_FAULT);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers; async rst drops the motor immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            status_q    <= 2'b00;
            prod_q      <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            gap_q       <= '0;
            motor_q     <= '0;
            coin_out_q  <= 2'b00;
            coin_stb_q  <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            prod_q      <= prod_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            gap_q       <= gap_d;
            motor_q     <= motor_d;
            coin_out_q  <= coin_out_d;
            coin_stb_q  <= coin_stb_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.motor    = motor_q;
    assign bus.coin_out = coin_out_q;
    assign bus.coin_stb = coin_stb_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.fault    = fault_q;

`ifdef VM_DISPENSE_STATS_EN
    logic [7:0] vend_q;
    logic       vend_inc;

    assign vend_inc = (state_q == S_MOTOR) && bus.slot_sense;

    // Saturating count of motor cycles that ended with the item detected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vend_q <= 8'd0;
        end else if (soft_rst) begin
            vend_q <= 8'd0;
        end else if (vend_inc && vend_q != 8'hFF) begin
            vend_q <= vend_q + 8'd1;
        end
    end

    assign bus.vend_cnt = vend_q;
`endif

endmodule

// File: tb/tb_vm_dispense_ctrl.sv
// tb/tb_vm_dispense_ctrl.sv - directed table-driven bench for vm_dispense_ctrl
module tb_vm_dispense_ctrl;
    import vm_pkg::*;

    localparam int MOTOR_TIMEOUT = 16;
    localparam int COIN_GAP      = 4;

    logic clk = 1'b0;
    logic rst;
    logic soft_rst;

    vm_dispense_ctrl_if bus();

    vm_dispense_ctrl #(.MOTOR_TIMEOUT(MOTOR_TIMEOUT), .COIN_GAP(COIN_GAP)) dut (
        .clk      (clk),
        .rst      (rst),
        .soft_rst (soft_rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  status;
        logic [2:0]  product;
        logic [15:0] balance;
        int          sense_at;
        logic [5:0]  exp_motor;
        int          exp_on;
        int          exp_ncoins;
        logic [7:0]  exp_codes;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[10];

    task automatic pulse_soft_rst();
        @(negedge clk);
        bus.status = 2'b00;
        soft_rst   = 1'b1;
        @(negedge clk);
        soft_rst   = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t       v;
        int         on_cnt, ncoins, ndone, last_coin, gap_bad, motor_bad, cyc, done_cyc;
        logic [7:0] codes;
        v = vecs[i];
        on_cnt = 0; ncoins = 0; ndone = 0; last_coin = -1;
        gap_bad = 0; motor_bad = 0; cyc = 0; done_cyc = -1; codes = 8'd0;
        pulse_soft_rst();
        chk($sformatf("v%0d fault_after_soft_rst", i), 32'(bus.fault), 0);
        chk($sformatf("v%0d busy_idle", i), 32'(bus.busy), 0);
        @(negedge clk);
        bus.status  = v.status;
        bus.product = v.product;
        bus.balance = v.balance;
        while (cyc < 150 && (done_cyc < 0 || cyc < done_cyc + 8)) begin
            @(negedge clk);
            cyc++;
            bus.slot_sense = 1'b0;
            if (bus.motor != 6'd0) begin
                on_cnt++;
                if (bus.motor !== v.exp_motor) motor_bad++;
            end
            if (bus.coin_stb === 1'b1) begin
                if (ncoins < 4) codes[2*ncoins +: 2] = bus.coin_out;
                if (last_coin >= 0 && cyc - last_coin != COIN_GAP) gap_bad++;
                last_coin = cyc;
                ncoins++;
            end
            if (bus.done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (v.sense_at > 0 && bus.motor != 6'd0 && on_cnt == v.sense_at) bus.slot_sense = 1'b1;
        end
        chk($sformatf("v%0d done_seen", i), 32'(done_cyc >= 0), 1);
        chk($sformatf("v%0d motor_value_bad", i), 32'(motor_bad), 0);
        chk($sformatf("v%0d motor_on_cycles", i), 32'(on_cnt), 32'(v.exp_on));
        chk($sformatf("v%0d coin_count", i), 32'(ncoins), 32'(v.exp_ncoins));
        chk($sformatf("v%0d coin_codes", i), 32'(codes), 32'(v.exp_codes));
        chk($sformatf("v%0d coin_spacing_bad", i), 32'(gap_bad), 0);
        chk($sformatf("v%0d done_pulses", i), 32'(ndone), 1);
        chk($sformatf("v%0d fault", i), 32'(bus.fault), 32'(v.exp_fault));
        chk($sformatf("v%0d busy_no_retrigger", i), 32'(bus.busy), 0);
`ifdef VM_DISPENSE_STATS_EN
        chk($sformatf("v%0d vend_cnt", i), 32'(bus.vend_cnt), (v.sense_at > 0) ? 32'd1 : 32'd0);
`endif
        bus.status = 2'b00;
    endtask

    // Runs until the first coin strobe, raising slot_sense on motor cycle sense_at
    task automatic wait_first_coin(input int sense_at, output int found, output int motor_cycles);
        int on_cnt;
        on_cnt = 0;
        found  = 0;
        for (int c = 0; c < 60 && found == 0; c++) begin
            @(negedge clk);
            bus.slot_sense = 1'b0;
            if (bus.motor != 6'd0) on_cnt++;
            if (bus.coin_stb === 1'b1) found = 1;
            if (sense_at > 0 && bus.motor != 6'd0 && on_cnt == sense_at) bus.slot_sense = 1'b1;
        end
        motor_cycles = on_cnt;
    endtask

    task automatic check_outputs_clear(input string tag);
        chk({tag, " motor"},    32'(bus.motor), 0);
        chk({tag, " coin_out"}, 32'(bus.coin_out), 0);
        chk({tag, " coin_stb"}, 32'(bus.coin_stb), 0);
        chk({tag, " busy"},     32'(bus.busy), 0);
        chk({tag, " done"},     32'(bus.done), 0);
        chk({tag, " fault"},    32'(bus.fault), 0);
    endtask

    initial begin
        int found, mcyc, coins, motor_seen, dones;

        //            status product bal  sense motor      on  n  codes         fault
        vecs[0] = '{2'b01, 3'd3, 16'd40, 5, 6'b000100,  5, 3, 8'b00_01_10_11, 1'b0};
        vecs[1] = '{2'b10, 3'd0, 16'd65, 0, 6'b000000,  0, 4, 8'b01_10_11_11, 1'b0};
        vecs[2] = '{2'b01, 3'd2, 16'd30, 0, 6'b000010, 16, 2, 8'b00_00_01_11, 1'b1};
        vecs[3] = '{2'b01, 3'd7, 16'd50, 0, 6'b000000,  0, 0, 8'b00_00_00_00, 1'b1};
        vecs[4] = '{2'b10, 3'd0, 16'd7,  0, 6'b000000,  0, 1, 8'b00_00_00_01, 1'b0};
        vecs[5] = '{2'b11, 3'd1, 16'd20, 0, 6'b000000,  0, 0, 8'b00_00_00_00, 1'b1};
        vecs[6] = '{2'b01, 3'd0, 16'd20, 0, 6'b000000,  0, 0, 8'b00_00_00_00, 1'b1};
        vecs[7] = '{2'b10, 3'd0, 16'd4,  0, 6'b000000,  0, 0, 8'b00_00_00_00, 1'b0};
        vecs[8] = '{2'b01, 3'd6, 16'd0,  1, 6'b100000,  1, 0, 8'b00_00_00_00, 1'b0};
        vecs[9] = '{2'b10, 3'd0, 16'd30, 0, 6'b000000,  0, 2, 8'b00_00_01_11, 1'b0};

        rst            = 1'b1;
        soft_rst       = 1'b0;
        bus.status     = 2'b00;
        bus.product    = 3'd0;
        bus.balance    = 16'd0;
        bus.slot_sense = 1'b0;
        #23;
        check_outputs_clear("reset");
`ifdef VM_DISPENSE_STATS_EN
        chk("reset vend_cnt", 32'(bus.vend_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i);

        // Second request while busy must be ignored
        pulse_soft_rst();
        @(negedge clk);
        bus.status  = 2'b10;
        bus.balance = 16'd65;
        wait_first_coin(0, found, mcyc);
        chk("busy_req first_coin_seen", 32'(found), 1);
        bus.status = 2'b00;
        @(negedge clk);
        bus.status  = 2'b01;
        bus.product = 3'd1;
        coins = 1; motor_seen = 0; dones = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.coin_stb === 1'b1) coins++;
            if (bus.motor != 6'd0) motor_seen++;
            if (bus.done === 1'b1) dones++;
        end
        chk("busy_req coin_total", 32'(coins), 4);
        chk("busy_req no_motor", 32'(motor_seen), 0);
        chk("busy_req done_pulses", 32'(dones), 1);
        chk("busy_req idle_after", 32'(bus.busy), 0);
        bus.status = 2'b00;

        // Async rst mid-CHANGE with a pending busy-time request
        pulse_soft_rst();
        @(negedge clk);
        bus.status  = 2'b01;
        bus.product = 3'd3;
        bus.balance = 16'd40;
        wait_first_coin(2, found, mcyc);
        chk("rst_change first_coin_seen", 32'(found), 1);
        chk("rst_change motor_cycles", 32'(mcyc), 2);
`ifdef VM_DISPENSE_STATS_EN
        chk("rst_change vend_cnt_before", 32'(bus.vend_cnt), 1);
`endif
        bus.status = 2'b00;
        @(negedge clk);
        bus.status  = 2'b01;
        bus.product = 3'd5;
        #2 rst = 1'b1;
        #1 check_outputs_clear("rst_change");
`ifdef VM_DISPENSE_STATS_EN
        chk("rst_change vend_cnt_after", 32'(bus.vend_cnt), 0);
`endif
        bus.status = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        coins = 0; motor_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.coin_stb === 1'b1) coins++;
            if (bus.motor != 6'd0 || bus.busy === 1'b1) motor_seen++;
        end
        chk("rst_change no_coins_after", 32'(coins), 0);
        chk("rst_change stays_idle", 32'(motor_seen), 0);

        // Async rst mid-MOTOR drops the motor without waiting for a clock
        @(negedge clk);
        bus.status  = 2'b01;
        bus.product = 3'd4;
        bus.balance = 16'd25;
        repeat (3) @(negedge clk);
        chk("rst_motor motor_on", 32'(bus.motor), 32'(6'b001000));
        #2 rst = 1'b1;
        #1 chk("rst_motor motor_dropped", 32'(bus.motor), 0);
        chk("rst_motor busy_dropped", 32'(bus.busy), 0);
        bus.status = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        coins = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.coin_stb === 1'b1) coins++;
        end
        chk("rst_motor no_coins_after", 32'(coins), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vm_dispense_ctrl.md
VM_DISPENSE_CTRL -- requirements
Module: vm_dispense_ctrl

Interface
REQ-001 Parameter: MOTOR_TIMEOUT, 16, max cycles motor stays on waiting for slot_sense.
REQ-002 Parameter: COIN_GAP, 4, cycles from one coin_stb to the next (coin_stb included).
REQ-003 Single clock domain; reset is asynchronous, active-high.
REQ-004 Port: clk  in  1  rising-edge system clock.
REQ-005 Port: rst  in  1  asynchronous active-high reset.
REQ-006 Port: soft_rst  in  1  synchronous clear, same effect as rst.
REQ-007 Port: product  in  3  slot from vending FSM; 0 = none, 1..6 = slot, 7 = invalid.
REQ-008 Port: status  in  2  vending FSM result; 00 IDLE, 01 VEND, 10 REFUND, 11 ERROR.
REQ-009 Port: balance  in  16  change owed in cents.
REQ-010 Port: slot_sense  in  1  item-drop sensor, active-high.
REQ-011 Port: motor  out  6  one-hot slot motor drive; bit n-1 drives slot n.
REQ-012 Port: coin_out  out  2  denomination code; 01 = 5c, 10 = 10c, 11 = 25c.
REQ-013 Port: coin_stb  out  1  one-cycle strobe qualifying coin_out.
REQ-014 Port: busy  out  1  high whenever state is not IDLE.
REQ-015 Port: done  out  1  one-cycle pulse on transaction completion.
REQ-016 Port: fault  out  1  sticky jam/invalid flag; cleared only by rst or soft_rst.

Function
REQ-017 FSM states: IDLE, MOTOR, CHANGE, GAP, DONE, FAULT.
REQ-018 Request accepted only in IDLE on the cycle status changes from 00 to non-zero (registered edge detect); product and balance latched that cycle.
REQ-019 status 01 with product 1..6: go to MOTOR next cycle; motor = one-hot(product).
REQ-020 status 01 with product 0 or 7, or status 11: go to FAULT; fault = 1; no motor and no coins.
REQ-021 status 10: skip MOTOR and go straight to CHANGE with latched balance.
REQ-022 MOTOR: motor deasserts the cycle after slot_sense = 1, then go to CHANGE.
REQ-023 MOTOR: if slot_sense is not seen within MOTOR_TIMEOUT cycles, deassert motor, set fault, go to CHANGE (full refund of latched balance).
REQ-024 CHANGE: greedy dispense; remaining >= 25 -> 25c, else >= 10 -> 10c, else >= 5 -> 5c.
REQ-025 Each dispense: coin_stb high one cycle, remaining decremented by that denomination, then GAP for COIN_GAP-1 cycles, then back to CHANGE.
REQ-026 CHANGE with remaining < 5: go to DONE; any 1..4c residue is discarded silently.
REQ-027 Remaining is 16-bit unsigned and never underflows.
REQ-028 DONE: done high one cycle, then IDLE.
REQ-029 FAULT (entered via REQ-020): done high one cycle, then IDLE.
REQ-030 Requests arriving while busy are ignored, not queued.
REQ-031 Outputs are registered; motor, coin_stb and done are glitch-free.

Reset
REQ-032 rst (async) or soft_rst (sync) forces IDLE and sets motor = 0, coin_out = 00, coin_stb = 0, busy = 0, done = 0, fault = 0, remaining = 0.
REQ-033 Reset mid-MOTOR drops motor in the same cycle as rst; no coins are dispensed afterwards.
REQ-034 After reset, the status edge detector treats the previous status as 00.

Configuration
REQ-035 Macro VM_DISPENSE_STATS_EN: when defined, adds output vend_cnt [7:0], a saturating count of successful MOTOR exits (slot_sense seen), reset to 0 by rst or soft_rst.
REQ-036 Without the macro, the port and its logic are absent and all other behaviour is identical.

Structure
REQ-037 Shared package vm_pkg holds: status encoding enum, coin denomination enum, denomination values (5/10/25), and the state enum.
REQ-038 One sub-module, vm_change_calc: combinational greedy denomination select and next-remaining calculation.

Verification
REQ-039 status 00->01, product 3, balance 40, slot_sense at cycle 5 -> motor 000100 until sense+1; coins 25, 10, 5 spaced 4 cycles apart; one done pulse; fault 0.
REQ-040 status 00->10, balance 65 -> no motor; coins 25, 25, 10, 5; done.
REQ-041 status 00->01, product 2, slot_sense never asserted, balance 30 -> motor off after 16 cycles; fault = 1; coins 25, 5.
REQ-042 status 00->01, product 7 -> FAULT; done pulse; no motor and no coin_stb; fault stays set until soft_rst.
REQ-043 balance 7 refund -> single 5c coin; 2c discarded; done.
REQ-044 rst asserted mid-CHANGE; second request issued while busy -> outputs cleared immediately; busy-time request ignored; with VM_DISPENSE_STATS_EN, vend_cnt = 0 after rst.
